// File: rtl/axi_ethernet_v3_01_a_cdc_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the bus-crossing launcher: FSM encodings and
// width helpers used to size the acknowledge-timeout counter.
package axi_ethernet_v3_01_a_cdc_pkg;

    typedef enum logic [1:0] {
        RESYNC   = 2'd0,
        IDLE     = 2'd1,
        WAIT_ACK = 2'd2
    } cdc_state_e;

    // Smallest r such that 2**r >= value (0 for value <= 1).
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((33'(1) << i) < 33'(value)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Counter must hold 0..timeout inclusive; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned timeout);
        int unsigned w;
        w = clog2(timeout + 1);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/axi_ethernet_v3_01_a_sync_block.sv
`timescale 1ns/1ps
// Two-flop synchronizer for a single asynchronous bit.
//   clk      : destination clock
//   data_in  : asynchronous input
//   data_out : synchronized output, two clk edges of latency
// The flops take INITIALISE at power-up and are deliberately not reset so
// the synchronized view of the peer survives a local reset.
module axi_ethernet_v3_01_a_sync_block #(
    parameter logic [1:0] INITIALISE = 2'b00
) (
    input  logic clk,
    input  logic data_in,
    output logic data_out
);

    logic sync1_q = INITIALISE[0];
    logic sync2_q = INITIALISE[1];

    always_ff @(posedge clk) begin
        sync1_q <= data_in;
        sync2_q <= sync1_q;
    end

    assign data_out = sync2_q;

endmodule

// File: rtl/axi_ethernet_v3_01_a_cdc_bus_tx.sv
`timescale 1ns/1ps
// Source-side launcher for a multi-bit word crossing clock domains with a
// two-phase (toggle) req/ack handshake.
//   clk, resetn  : source clock, synchronous active-low reset
//   data_in      : word to transfer, sampled only on the accept edge
//   data_valid   : data_in valid
//   data_ready   : block can accept a word (IDLE)
//   data_out     : held word, stable from the req_out toggle until done
//   req_out      : request toggle to the destination domain
//   ack_in       : acknowledge toggle from the destination (asynchronous)
//   busy         : transfer outstanding
//   done         : one-cycle pulse when the ack is observed
//   timeout      : one-cycle pulse when the wait reaches TIMEOUT_CYCLES
module axi_ethernet_v3_01_a_cdc_bus_tx
    import axi_ethernet_v3_01_a_cdc_pkg::*;
#(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             req_out,
    input  logic             ack_in,
    output logic             busy,
    output logic             done,
    output logic             timeout
);

    localparam int unsigned   CNT_W      = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
    localparam bit            TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    cdc_state_e       state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             req_q, req_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fired_q, fired_d;
    logic             ack_sync;
    logic             balanced;

    axi_ethernet_v3_01_a_sync_block #(
        .INITIALISE (2'b00)
    ) u_ack_sync (
        .clk      (clk),
        .data_in  (ack_in),
        .data_out (ack_sync)
    );

    // Handshake is at rest when the peer has echoed our last toggle.
    assign balanced = (ack_sync == req_q);

    assign data_out = data_q;
    assign req_out  = req_q;

    // Next-state and status decode; status depends only on registers.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        req_d      = req_q;
        cnt_d      = cnt_q;
        fired_d    = fired_q;
        data_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        timeout    = 1'b0;

        case (state_q)
            RESYNC: begin
                if (balanced) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                data_ready = 1'b1;
                if (data_valid) begin
                    data_d  = data_in;
                    req_d   = ~req_q;
                    cnt_d   = '0;
                    fired_d = 1'b0;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                busy = 1'b1;
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                // Counter saturates, so a fired flag keeps the pulse single.
                if (TIMEOUT_EN && (cnt_q == CNT_MAX) && !fired_q) begin
                    timeout = 1'b1;
                    fired_d = 1'b1;
                end
                // Never abandon a transfer: only the ack leaves this state.
                if (balanced) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = RESYNC;
            end
        endcase
    end

    // State registers; reset drops any in-flight transfer and resyncs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= RESYNC;
            data_q  <= '0;
            req_q   <= 1'b0;
            cnt_q   <= '0;
            fired_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
            fired_q <= fired_d;
        end
    end

endmodule

// File: tb/tb_axi_ethernet_v3_01_a_cdc_bus_tx.sv
`timescale 1ns/1ps
// Self-checking bench for the toggle-handshake bus launcher.
module tb_axi_ethernet_v3_01_a_cdc_bus_tx;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned TO_CYC = 15;
    localparam int unsigned N_RAND = 1000;

    logic             clk        = 1'b0;
    logic             resetn     = 1'b0;
    logic [WIDTH-1:0] data_in    = '0;
    logic             data_valid = 1'b0;
    logic             ack_in     = 1'b0;
    logic             data_ready;
    logic [WIDTH-1:0] data_out;
    logic             req_out;
    logic             busy;
    logic             done;
    logic             timeout;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Reference model state
    logic        exp_req = 1'b0;
    logic [31:0] held, nxt, last_word;
    logic [31:0] sent_q[$];
    logic [31:0] rx_q[$];
    int unsigned n, to_cnt, acc, dn, tos, cyc;
    bit          saw, pend, stop;

    axi_ethernet_v3_01_a_cdc_bus_tx #(
        .WIDTH          (WIDTH),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .data_out   (data_out),
        .req_out    (req_out),
        .ack_in     (ack_in),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a word and return just after the accept edge.
    task automatic send(input logic [31:0] w, input bit keep_valid);
        int unsigned k;
        k = 0;
        data_in    = w;
        data_valid = 1'b1;
        while (!data_ready && k < 200) begin
            tick();
            k++;
        end
        check("send_ready", 32'(data_ready), 32'd1);
        tick();
        exp_req = ~exp_req;
        if (!keep_valid) data_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int unsigned k;
        k = 0;
        while (!done && k < 100) begin
            tick();
            k++;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        // Reset and release with the peer at rest
        resetn = 1'b0;
        repeat (3) tick();
        check("rst_ready",   32'(data_ready), 32'd0);
        check("rst_req",     32'(req_out),    32'd0);
        check("rst_data",    data_out,        32'd0);
        check("rst_busy",    32'(busy),       32'd0);
        check("rst_done",    32'(done),       32'd0);
        check("rst_timeout", 32'(timeout),    32'd0);
        resetn = 1'b1;
        tick();
        check("rel_ready", 32'(data_ready), 32'd1);
        check("rel_busy",  32'(busy),       32'd0);
        check("rel_req",   32'(req_out),    32'd0);

        // First word, peer acks 5 cycles after the toggle
        send(32'hDEADBEEF, 1'b0);
        check("w1_req",   32'(req_out),    32'd1);
        check("w1_data",  data_out,        32'hDEADBEEF);
        check("w1_busy",  32'(busy),       32'd1);
        check("w1_ready", 32'(data_ready), 32'd0);
        repeat (4) tick();
        ack_in = 1'b1;
        tick();
        check("w1_done_early", 32'(done), 32'd0);
        tick();
        check("w1_done",    32'(done),    32'd1);
        check("w1_no_to",   32'(timeout), 32'd0);
        tick();
        check("w1_done_end", 32'(done),       32'd0);
        check("w1_ready2",   32'(data_ready), 32'd1);

        // Second word toggles req back to 0
        send(32'h12345678, 1'b0);
        check("w2_req",  32'(req_out), 32'd0);
        check("w2_data", data_out,     32'h12345678);
        ack_in = 1'b0;
        tick();
        tick();
        check("w2_done", 32'(done), 32'd1);
        tick();
        check("w2_ready", 32'(data_ready), 32'd1);

        // Valid held high with changing data during the wait
        held = 32'hA5A50001;
        send(held, 1'b1);
        for (int i = 0; i < 6; i++) begin
            data_in = $urandom;
            tick();
            check("hold_data", data_out,     held);
            check("hold_req",  32'(req_out), 32'(exp_req));
        end
        ack_in = exp_req;
        saw = 1'b0;
        n = 0;
        while (!data_ready && n < 20) begin
            data_in = $urandom;
            tick();
            if (done) saw = 1'b1;
            check("hold_data2", data_out, held);
            n++;
        end
        check("hold_done_first", 32'(saw), 32'd1);
        nxt = data_in;
        tick();
        exp_req = ~exp_req;
        check("hold_next_data", data_out,     nxt);
        check("hold_next_req",  32'(req_out), 32'(exp_req));
        data_valid = 1'b0;
        ack_in = exp_req;
        wait_done("hold_next_done");
        tick();

        // Timeout with no ack, late ack still completes
        send(32'h0BADF00D, 1'b0);
        to_cnt = 0;
        for (int k = 1; k < 40; k++) begin
            tick();
            if (timeout) to_cnt++;
            if (k >= 14 && k <= 16) check($sformatf("to_at_%0d", k), 32'(timeout), 32'(k == 15));
        end
        check("to_once",    to_cnt,        32'd1);
        check("to_busy",    32'(busy),     32'd1);
        check("to_data",    data_out,      32'h0BADF00D);
        ack_in = exp_req;
        tick();
        check("to_done_early", 32'(done), 32'd0);
        tick();
        check("to_late_done", 32'(done),    32'd1);
        check("to_no_refire", 32'(timeout), 32'd0);
        tick();
        check("to_idle", 32'(data_ready), 32'd1);

        // Reset mid-transfer while the peer's ack sits at 1
        if (!exp_req) begin
            send(32'h11111111, 1'b0);
            ack_in = 1'b1;
            wait_done("pre_rst_done");
            tick();
        end
        send(32'h22222222, 1'b0);
        check("pre_rst_busy", 32'(busy), 32'd1);
        resetn = 1'b0;
        tick();
        check("mid_rst_req",   32'(req_out),    32'd0);
        check("mid_rst_data",  data_out,        32'd0);
        check("mid_rst_ready", 32'(data_ready), 32'd0);
        check("mid_rst_busy",  32'(busy),       32'd0);
        tick();
        resetn  = 1'b1;
        exp_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("resync_ready", 32'(data_ready), 32'd0);
            check("resync_done",  32'(done),       32'd0);
            check("resync_to",    32'(timeout),    32'd0);
        end
        ack_in = 1'b0;
        tick();
        check("resync_r1", 32'(data_ready), 32'd0);
        tick();
        check("resync_r2", 32'(data_ready), 32'd0);
        tick();
        check("resync_r3", 32'(data_ready), 32'd1);

        // Randomized traffic against a peer with random asynchronous ack timing
        last_word = 32'd0;
        acc = 0; dn = 0; tos = 0; cyc = 0;
        pend = 1'b0;
        stop = 1'b0;
        fork
            begin
                while (!stop) begin
                    tick();
                    if (req_out != ack_in) begin
                        rx_q.push_back(data_out);
                        repeat ($urandom_range(0, 9)) tick();
                        #($urandom_range(1, 8));
                        ack_in = req_out;
                    end
                end
            end
            begin
                while ((acc < N_RAND || dn < acc) && cyc < 40000) begin
                    tick();
                    cyc++;
                    if (pend) begin
                        acc++;
                        exp_req   = ~exp_req;
                        last_word = data_in;
                        sent_q.push_back(data_in);
                    end
                    if (done) dn++;
                    if (timeout) tos++;
                    check("rnd_req",  32'(req_out), 32'(exp_req));
                    check("rnd_data", data_out,     last_word);
                    if (acc < N_RAND) begin
                        data_valid = ($urandom_range(0, 3) != 0);
                        data_in    = $urandom;
                    end else begin
                        data_valid = 1'b0;
                    end
                    pend = data_valid && data_ready;
                end
                stop = 1'b1;
            end
        join
        check("rnd_accepts",  acc,                 N_RAND);
        check("rnd_done_cnt", dn,                  acc);
        check("rnd_no_to",    tos,                 32'd0);
        check("rnd_rx_count", 32'(rx_q.size()),    32'(sent_q.size()));
        for (int i = 0; i < sent_q.size() && i < rx_q.size(); i++) begin
            check("rnd_order", rx_q[i], sent_q[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_ethernet_v3_01_a_cdc_bus_tx.md
# axi_ethernet_v3_01_a_cdc_bus_tx

Source-domain launcher for a multi-bit value crossing to another clock domain using a two-phase toggle req/ack handshake. The block captures a word on a valid/ready handshake, holds it stable on `data_out`, and toggles `req_out`. It then waits for the far-end receiver's `ack_in` toggle, synchronized internally, before accepting the next word. It sits in the sending clock domain, opposite the receive-side synchronizer that samples `data_out` after detecting the `req_out` toggle.

## Interface
- `WIDTH`, 32: width of transferred word.
- `TIMEOUT_CYCLES`, 1023: WAIT_ACK cycles before `timeout` pulses; 0 disables the timeout.
- `clk` in 1: source-domain clock; all logic on rising edge.
- `resetn` in 1: reset is synchronous and active-low.
- `data_in` in WIDTH: word to transfer.
- `data_valid` in 1: `data_in` valid.
- `data_ready` out 1: block can accept a word.
- `data_out` out WIDTH: registered word; stable from `req_out` toggle until `done`.
- `req_out` out 1: request toggle, registered, to destination domain.
- `ack_in` in 1: acknowledge toggle from destination domain; asynchronous to `clk`.
- `busy` out 1: transfer outstanding (state WAIT_ACK).
- `done` out 1: one-cycle pulse when ack observed.
- `timeout` out 1: one-cycle pulse when WAIT_ACK reaches `TIMEOUT_CYCLES`.

## Operation
- `ack_in` passes through a two-flop synchronizer to give `ack_sync`. The synchronizer flops power up 0 and are not reset.
- The handshake is balanced when `ack_sync == req_out`.
- FSM states:
  - RESYNC (reset state): stays until balanced, then → IDLE.
  - IDLE: `data_ready=1`. On `data_valid && data_ready`, the same edge loads `data_out<=data_in`, toggles `req_out`, clears the counter, and goes → WAIT_ACK.
  - WAIT_ACK: counter increments each cycle and saturates at `TIMEOUT_CYCLES`. When balanced: `done=1` that cycle, → IDLE next edge.
- `timeout` pulses exactly once, in the cycle the counter first equals `TIMEOUT_CYCLES` (only when nonzero). The FSM stays in WAIT_ACK; it never abandons a transfer, which preserves toggle parity. A late ack still produces `done`.
- `data_valid` while not ready is ignored; there is no buffering. `data_in` is sampled only on the accept edge.
- `data_out` and `req_out` change only on the accept edge.
- Reset mid-transfer:
  - `req_out` and `data_out` go to 0.
  - The FSM enters RESYNC and waits for the peer's `ack_sync` to also read 0. No `done` or `timeout` fires for the lost transfer.
- Counter width is clog2(`TIMEOUT_CYCLES`+1), minimum 1.

## Timing
- Reset values:
  - `data_ready=0`, `data_out=0`, `req_out=0`, `busy=0`, `done=0`, `timeout=0`.
  - FSM=RESYNC, counter=0.
- With `ack_sync` already 0, `data_ready` rises 1 cycle after `resetn` deasserts.
- Accept at edge N: `req_out`, `data_out`, and `busy` are valid after N; `data_ready=0` after N.
- `ack_in` toggling before edge M: `ack_sync` updates after M+1, `done` is high in the cycle after M+1, and `data_ready=1` after M+2.
- Minimum throughput, with the peer acking immediately: one word per 4 + destination-latency cycles.
- `done`, `timeout`, and `data_ready` are combinational from state/registers only, never from `ack_in` directly.
- Simultaneous `done` and `timeout` in the same cycle: both assert.

## Structure
- Shared package/include `axi_ethernet_v3_01_a_cdc_pkg`: FSM state encodings (RESYNC=2'd0, IDLE=2'd1, WAIT_ACK=2'd2) and a clog2 function.
- One sub-module: `axi_ethernet_v3_01_a_sync_block` instance (INITIALISE=2'b00) on `ack_in`. Placement constraints stay inside that primitive.
- Top: FSM, counter, data/req registers; roughly 150 lines.

## Test plan
- Reset, then `ack_in=0`: `data_ready=1` one cycle after release; all other outputs 0.
- Send 0xDEADBEEF; model acks 5 cycles after the `req_out` toggle:
  - `req_out` 0→1 and `data_out`=0xDEADBEEF after the accept edge.
  - `done` pulses 2 cycles after the ack toggle.
  - Second word 0x12345678 toggles `req_out` 1→0.
- Hold `data_valid` high and change `data_in` every cycle during WAIT_ACK: `data_out` stays at the accepted value; the next word is accepted only after `done`.
- `TIMEOUT_CYCLES=15`, no ack:
  - `timeout` pulses once, 15 cycles after accept.
  - Ack at cycle 40 → `done`, return to IDLE.
- Reset asserted mid-WAIT_ACK with the peer's ack held at 1: `data_ready` stays 0 (RESYNC) until `ack_in` returns to 0; then ready 3 cycles later.
- Randomized `ack_in` latency with asynchronous `ack_in` edges, 1000 words: scoreboard shows every word delivered in order, `data_out` stable whenever req≠ack, and `done` count equals accept count.
